// File: rtl/mode_sequencer_pkg.sv
// Shared clock-design package: mode encodings, default edit-mode mask,
// key debounce time and the key press-event helper.
package mode_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_CLK_SHOW  = 2'd0,
    MODE_CLK_SET   = 2'd1,
    MODE_RING_SHOW = 2'd2,
    MODE_RING_SET  = 2'd3
  } mode_e;

  // Edit modes of the standard four-mode clock: the two "set" modes.
  localparam logic [3:0] DEFAULT_EDIT_MASK = (4'b0001 << MODE_CLK_SET) | (4'b0001 << MODE_RING_SET);

  // Debounce time of the key filters: 20 ms at 50 MHz.
  localparam int KEY_DEBOUNCE_CYC = 1_000_000;

  // A press is a debounced transition into the pressed (low) level.
  function automatic logic is_press(input logic key_flag, input logic key_state);
    return key_flag & ~key_state;
  endfunction

endpackage

// File: rtl/key_filter.sv
// Debounces one raw active-low key pin. key_state is the debounced level
// (1 = released), key_flag pulses for one cycle whenever key_state changes.
module key_filter
  import mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_pin,
  output logic key_flag,
  output logic key_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchronizer for the asynchronous pin; idles at released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_pin};
    end
  end

  // Accept a new level only after it has been stable for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      key_state <= 1'b1;
      key_flag  <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      if (sync_r[1] == key_state) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r     <= {CNT_W{1'b0}};
        key_state <= sync_r[1];
        key_flag  <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Key-driven mode selector for the digital clock: next/prev/home keys step
// through NUM_MODES modes, edit modes enable the keyboard, leaving an edit mode
// by key pulses commit, and inactivity in a non-zero mode falls back to mode 0.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter int                   NUM_MODES    = 4,
  parameter logic [NUM_MODES-1:0] EDIT_MASK    = NUM_MODES'(DEFAULT_EDIT_MASK),
  parameter int                   TIMEOUT_CYC  = 500000,
  parameter int                   USE_FILTER   = 1,
  parameter int                   DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
  localparam int                  MODE_W       = $clog2(NUM_MODES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_next,
  input  logic                 key_prev,
  input  logic                 key_home,
  output logic [MODE_W-1:0]    mode_idx,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 en_keyboard,
  output logic                 commit_pulse,
  output logic                 timeout_pulse
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam int                CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam bit                TIMEOUT_EN = (TIMEOUT_CYC > 0);

  logic                 next_ev_s;
  logic                 prev_ev_s;
  logic                 home_ev_s;
  logic                 any_press_s;
  logic                 timeout_hit_s;
  logic                 key_move_s;
  logic [MODE_W-1:0]    mode_nxt_s;
  logic [NUM_MODES-1:0] onehot_nxt_s;
  logic [CNT_W-1:0]     idle_cnt_r;
  logic [CNT_W-1:0]     idle_nxt_s;

  // Press events: debounced pin edges, or the inputs themselves when already clean.
  if (USE_FILTER != 0) begin : g_filter
    logic [2:0] pin_s;
    logic [2:0] flag_s;
    logic [2:0] state_s;

    assign pin_s = {key_home, key_prev, key_next};

    for (genvar k = 0; k < 3; k++) begin : g_key
      key_filter #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_key_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_pin  (pin_s[k]),
        .key_flag (flag_s[k]),
        .key_state(state_s[k])
      );
    end

    assign next_ev_s = is_press(flag_s[0], state_s[0]);
    assign prev_ev_s = is_press(flag_s[1], state_s[1]);
    assign home_ev_s = is_press(flag_s[2], state_s[2]);
  end else begin : g_raw
    assign next_ev_s = key_next;
    assign prev_ev_s = key_prev;
    assign home_ev_s = key_home;
  end

  assign any_press_s   = next_ev_s | prev_ev_s | home_ev_s;
  assign timeout_hit_s = TIMEOUT_EN && (mode_idx != {MODE_W{1'b0}}) &&
                         (idle_cnt_r == CNT_LAST) && !any_press_s;

  // Next mode: home beats a single-direction step, which beats the idle timeout.
  always_comb begin
    mode_nxt_s = mode_idx;
    key_move_s = 1'b0;
    if (home_ev_s) begin
      mode_nxt_s = {MODE_W{1'b0}};
      key_move_s = (mode_idx != {MODE_W{1'b0}});
    end else if (next_ev_s ^ prev_ev_s) begin
      key_move_s = 1'b1;
      if (next_ev_s) begin
        mode_nxt_s = (mode_idx == MODE_LAST) ? {MODE_W{1'b0}} : (mode_idx + MODE_W'(1));
      end else begin
        mode_nxt_s = (mode_idx == {MODE_W{1'b0}}) ? MODE_LAST : (mode_idx - MODE_W'(1));
      end
    end else if (timeout_hit_s) begin
      mode_nxt_s = {MODE_W{1'b0}};
    end else begin
      mode_nxt_s = mode_idx;
    end
  end

  // Idle counter: restarts on activity, in mode 0, on timeout, or when disabled.
  always_comb begin
    idle_nxt_s = {CNT_W{1'b0}};
    if (any_press_s || (mode_idx == {MODE_W{1'b0}}) || timeout_hit_s || !TIMEOUT_EN) begin
      idle_nxt_s = {CNT_W{1'b0}};
    end else begin
      idle_nxt_s = idle_cnt_r + CNT_W'(1);
    end
  end

  // One-hot decode of the upcoming mode so it can be registered with mode_idx.
  always_comb begin
    onehot_nxt_s = {NUM_MODES{1'b0}};
    for (int i = 0; i < NUM_MODES; i++) begin
      onehot_nxt_s[i] = (mode_nxt_s == MODE_W'(i));
    end
  end

  // Mode, decode, keyboard enable, pulses and idle count all update on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_idx      <= {MODE_W{1'b0}};
      mode_onehot   <= NUM_MODES'(1);
      en_keyboard   <= EDIT_MASK[0];
      commit_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
      idle_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      mode_idx      <= mode_nxt_s;
      mode_onehot   <= onehot_nxt_s;
      en_keyboard   <= EDIT_MASK[mode_nxt_s];
      commit_pulse  <= key_move_s & EDIT_MASK[mode_idx];
      timeout_pulse <= timeout_hit_s;
      idle_cnt_r    <= idle_nxt_s;
    end
  end

endmodule
